compressed_fetch_aligner: RTL and testbench

- Sits between instruction fetch and the compressed-instruction decoder of the RV32EC core.
- Accepts aligned 32-bit fetch words into a parametrised halfword FIFO and carves out a stream of 16-bit (compressed) and 32-bit instructions.
- Handles 32-bit instructions that straddle word boundaries, and branch targets that start on an odd halfword.
- Tags each instruction with its PC, size and a basic illegal-encoding flag.

---
 rtl/compressed_fetch_aligner_if.sv | 27 ++
 rtl/compressed_fetch_aligner.sv | 97 +++++++++
 tb/tb_compressed_fetch_aligner.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/compressed_fetch_aligner_if.sv
// Fetch-side and decoder-side handshake bundle for the compressed fetch aligner.
// The slave modport is the aligner's view; master is the fetch unit / decoder environment.
interface compressed_fetch_aligner_if #(
  parameter int unsigned PC_WIDTH = 32
);
  logic [31:0]         FetchData;
  logic                FetchValid;
  logic                FetchReady;
  logic                Flush;
  logic [PC_WIDTH-1:0] FlushPc;
  logic                InstrValid;
  logic                InstrReady;
  logic [31:0]         InstrOut;
  logic                InstrIsCompressed;
  logic [PC_WIDTH-1:0] InstrPc;
  logic                InstrIllegal;

  modport master (
    output FetchData, FetchValid, Flush, FlushPc, InstrReady,
    input  FetchReady, InstrValid, InstrOut, InstrIsCompressed, InstrPc, InstrIllegal
  );

  modport slave (
    input  FetchData, FetchValid, Flush, FlushPc, InstrReady,
    output FetchReady, InstrValid, InstrOut, InstrIsCompressed, InstrPc, InstrIllegal
  );
endinterface

// File: rtl/compressed_fetch_aligner.sv
// Carves 16/32-bit RV32EC instructions out of aligned 32-bit fetch words via a halfword FIFO.
// Instruction outputs are combinational from the FIFO head; no extra pipeline stage.
module compressed_fetch_aligner #(
  parameter int unsigned         BUF_HALVES = 4,
  parameter int unsigned         PC_WIDTH   = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC   = '0
) (
  input logic                       Clk,
  input logic                       Reset,
  compressed_fetch_aligner_if.slave bus
);

  localparam int unsigned PtrW = $clog2(BUF_HALVES);
  localparam int unsigned CntW = $clog2(BUF_HALVES + 1);

  logic [15:0]         r_buf [BUF_HALVES];
  logic [PtrW-1:0]     r_rd_ptr;
  logic [PtrW-1:0]     r_wr_ptr;
  logic [CntW-1:0]     r_count;
  logic [PC_WIDTH-1:0] r_pc;
  logic                r_drop_first;

  logic [15:0]         w_head;
  logic [15:0]         w_head_hi;
  logic                w_is32;
  logic                w_instr_valid;
  logic                w_fetch_ready;
  logic                w_push;
  logic                w_pop;
  logic [CntW-1:0]     w_push_n;
  logic [CntW-1:0]     w_pop_n;
  logic                w_unused_flush_pc0;

  assign w_head    = r_buf[r_rd_ptr];
  assign w_head_hi = r_buf[r_rd_ptr + PtrW'(1)];
  assign w_is32    = (w_head[1:0] == 2'b11);

  // A 32-bit head waits here until its upper half has arrived (straddle case).
  always_comb begin
    w_instr_valid = 1'b0;
    if (!Reset && !bus.Flush) begin
      w_instr_valid = w_is32 ? (r_count >= CntW'(2)) : (r_count >= CntW'(1));
    end
  end

  assign w_fetch_ready = !bus.Flush && !Reset && (r_count <= CntW'(BUF_HALVES - 2));
  assign w_push        = bus.FetchValid && w_fetch_ready;
  assign w_pop         = w_instr_valid && bus.InstrReady;
  assign w_push_n      = !w_push ? '0 : (r_drop_first ? CntW'(1) : CntW'(2));
  assign w_pop_n       = !w_pop ? '0 : (w_is32 ? CntW'(2) : CntW'(1));

  assign w_unused_flush_pc0 = bus.FlushPc[0];

  assign bus.FetchReady        = w_fetch_ready;
  assign bus.InstrValid        = w_instr_valid;
  assign bus.InstrOut          = w_is32 ? {w_head_hi, w_head} : {16'h0000, w_head};
  assign bus.InstrIsCompressed = !w_is32;
  assign bus.InstrPc           = r_pc;
  assign bus.InstrIllegal      = w_is32 ? (w_head[4:2] == 3'b111) : (w_head == 16'h0000);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < BUF_HALVES; i++) begin
        r_buf[i] <= '0;
      end
      r_rd_ptr     <= '0;
      r_wr_ptr     <= '0;
      r_count      <= '0;
      r_pc         <= {RESET_PC[PC_WIDTH-1:1], 1'b0};
      r_drop_first <= RESET_PC[1];
    end else if (bus.Flush) begin
      r_rd_ptr     <= '0;
      r_wr_ptr     <= '0;
      r_count      <= '0;
      r_pc         <= {bus.FlushPc[PC_WIDTH-1:1], 1'b0};
      r_drop_first <= bus.FlushPc[1];
    end else begin
      if (w_push) begin
        // Odd-halfword branch target: the lower half of the first word is skipped.
        if (r_drop_first) begin
          r_buf[r_wr_ptr] <= bus.FetchData[31:16];
          r_drop_first    <= 1'b0;
        end else begin
          r_buf[r_wr_ptr]            <= bus.FetchData[15:0];
          r_buf[r_wr_ptr + PtrW'(1)] <= bus.FetchData[31:16];
        end
        r_wr_ptr <= r_wr_ptr + PtrW'(w_push_n);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PtrW'(w_pop_n);
        r_pc     <= r_pc + (w_is32 ? PC_WIDTH'(4) : PC_WIDTH'(2));
      end
      r_count <= r_count + w_push_n - w_pop_n;
    end
  end

endmodule

// File: tb/tb_compressed_fetch_aligner.sv
// Directed bench for compressed_fetch_aligner: a queue of expected instructions is filled as
// words are fed and drained as the aligner hands instructions to the decoder side.
module tb_compressed_fetch_aligner;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        comp;
    logic        ill;
  } exp_t;

  logic clk;
  logic rst;
  exp_t sb[$];
  int   n_checks;
  int   n_errors;
  int   n_words;
  logic fetch_acc;

  compressed_fetch_aligner_if #(.PC_WIDTH(32)) bus ();

  compressed_fetch_aligner #(
    .BUF_HALVES(4),
    .PC_WIDTH  (32),
    .RESET_PC  (32'h0000_0000)
  ) dut (
    .Clk  (clk),
    .Reset(rst),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic [31:0] instr, input logic [31:0] pc, input logic comp,
                          input logic ill);
    exp_t e;
    e.instr = instr;
    e.pc    = pc;
    e.comp  = comp;
    e.ill   = ill;
    sb.push_back(e);
  endtask

  // Sample on the falling edge; any instruction handshake pops and compares the scoreboard.
  task automatic sample_edge();
    exp_t e;
    @(negedge clk);
    fetch_acc = bus.FetchValid && bus.FetchReady;
    if (bus.InstrValid && bus.InstrReady) begin
      n_checks++;
      assert (sb.size() > 0) else begin
        n_errors++;
        $error("FAIL sb_underflow observed instr %h pc %h expected none", bus.InstrOut,
               bus.InstrPc);
      end
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("sb_instr", bus.InstrOut, e.instr);
        chk("sb_pc", bus.InstrPc, e.pc);
        chk("sb_comp", 32'(bus.InstrIsCompressed), 32'(e.comp));
        chk("sb_ill", 32'(bus.InstrIllegal), 32'(e.ill));
      end
    end
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
  endtask

  task automatic feed(input logic [31:0] word);
    int g;
    bus.FetchValid = 1'b1;
    bus.FetchData  = word;
    g = 0;
    do begin
      sample_edge();
      advance();
      g++;
    end while (!fetch_acc && g < 50);
    chk("feed_accept", 32'(fetch_acc), 32'd1);
    bus.FetchValid = 1'b0;
  endtask

  task automatic drain();
    int g;
    g = 0;
    while (sb.size() != 0 && g < 30) begin
      sample_edge();
      advance();
      g++;
    end
    chk("drain_empty", 32'(sb.size()), 32'd0);
  endtask

  task automatic flush(input logic [31:0] pc);
    bus.Flush   = 1'b1;
    bus.FlushPc = pc;
    sample_edge();
    chk("flush_fetch_ready", 32'(bus.FetchReady), 32'd0);
    chk("flush_instr_valid", 32'(bus.InstrValid), 32'd0);
    advance();
    bus.Flush = 1'b0;
  endtask

  function automatic logic [31:0] full_word(input int w);
    logic [15:0] lo;
    logic [15:0] hi;
    lo = 16'h1000 + 16'(w * 8);
    hi = 16'h1000 + 16'(w * 8 + 4);
    return {hi, lo};
  endfunction

  task automatic handle_acc();
    logic [31:0] wd;
    if (fetch_acc) begin
      wd = full_word(n_words);
      push_exp({16'h0, wd[15:0]}, 32'h200 + 32'(n_words * 4), 1'b1, 1'b0);
      push_exp({16'h0, wd[31:16]}, 32'h202 + 32'(n_words * 4), 1'b1, 1'b0);
      n_words++;
      bus.FetchData = full_word(n_words);
    end
  endtask

  initial begin
    n_checks       = 0;
    n_errors       = 0;
    n_words        = 0;
    fetch_acc      = 1'b0;
    rst            = 1'b1;
    bus.FetchData  = '0;
    bus.FetchValid = 1'b0;
    bus.Flush      = 1'b0;
    bus.FlushPc    = '0;
    bus.InstrReady = 1'b0;

    sample_edge();
    chk("rst_fetch_ready", 32'(bus.FetchReady), 32'd0);
    chk("rst_instr_valid", 32'(bus.InstrValid), 32'd0);
    advance();
    rst = 1'b0;
    sample_edge();
    chk("idle_fetch_ready", 32'(bus.FetchReady), 32'd1);
    chk("idle_instr_valid", 32'(bus.InstrValid), 32'd0);
    chk("idle_pc", bus.InstrPc, 32'h0);
    advance();

    // Two compressed halves in one word.
    bus.InstrReady = 1'b1;
    push_exp(32'h0000_4501, 32'h0, 1'b1, 1'b0);
    push_exp(32'h0000_0001, 32'h2, 1'b1, 1'b0);
    feed(32'h0001_4501);
    drain();

    // 32-bit instruction straddling two fetch words.
    flush(32'h0);
    push_exp(32'h0000_0001, 32'h0, 1'b1, 1'b0);
    feed(32'h0513_0001);
    sample_edge();
    advance();
    sample_edge();
    chk("straddle_wait0", 32'(bus.InstrValid), 32'd0);
    advance();
    sample_edge();
    chk("straddle_wait1", 32'(bus.InstrValid), 32'd0);
    advance();
    push_exp(32'h0000_0513, 32'h2, 1'b0, 1'b0);
    push_exp(32'h0000_0000, 32'h6, 1'b1, 1'b1);
    feed(32'h0000_0000);
    drain();

    // Flush while an instruction is pending and a fetch is offered.
    bus.InstrReady = 1'b0;
    feed(32'h0001_0001);
    sample_edge();
    chk("preflush_valid", 32'(bus.InstrValid), 32'd1);
    advance();
    bus.InstrReady = 1'b1;
    bus.FetchValid = 1'b1;
    bus.FetchData  = 32'hDEAD_BEEF;
    flush(32'h100);
    bus.FetchValid = 1'b0;
    sample_edge();
    chk("postflush_empty", 32'(bus.InstrValid), 32'd0);
    advance();
    push_exp(32'h0000_4505, 32'h100, 1'b1, 1'b0);
    push_exp(32'h0000_4501, 32'h102, 1'b1, 1'b0);
    feed(32'h4501_4505);
    drain();

    // Odd-halfword target drops the lower half.
    flush(32'h102);
    push_exp(32'h0000_4505, 32'h102, 1'b1, 1'b0);
    feed(32'h4505_FFFF);
    drain();
    sample_edge();
    chk("drop_nothing_left", 32'(bus.InstrValid), 32'd0);
    advance();

    // Back-pressure: buffer fills, then drains with fetch resuming.
    flush(32'h200);
    bus.InstrReady = 1'b0;
    n_words        = 0;
    bus.FetchValid = 1'b1;
    bus.FetchData  = full_word(0);
    for (int c = 0; c < 6; c++) begin
      sample_edge();
      advance();
      handle_acc();
    end
    sample_edge();
    chk("full_fetch_ready", 32'(bus.FetchReady), 32'd0);
    chk("full_words", 32'(n_words), 32'd2);
    chk("full_instr_valid", 32'(bus.InstrValid), 32'd1);
    advance();
    handle_acc();
    bus.InstrReady = 1'b1;
    sample_edge();
    chk("resume_ready_cnt4", 32'(bus.FetchReady), 32'd0);
    advance();
    handle_acc();
    sample_edge();
    chk("resume_ready_cnt3", 32'(bus.FetchReady), 32'd0);
    advance();
    handle_acc();
    sample_edge();
    chk("resume_ready_cnt2", 32'(bus.FetchReady), 32'd1);
    advance();
    handle_acc();
    for (int g = 0; g < 60 && n_words < 5; g++) begin
      sample_edge();
      advance();
      handle_acc();
    end
    chk("full_words_total", 32'(n_words), 32'd5);
    bus.FetchValid = 1'b0;
    drain();

    // Illegal encodings: all-zero halves and a >=48-bit prefix.
    flush(32'h0);
    push_exp(32'h0000_0000, 32'h0, 1'b1, 1'b1);
    push_exp(32'h0000_0000, 32'h2, 1'b1, 1'b1);
    push_exp(32'h0000_001F, 32'h4, 1'b0, 1'b1);
    feed(32'h0000_0000);
    feed(32'h0000_001F);
    drain();

    // PC wraps past the top of the address space.
    flush(32'hFFFF_FFFE);
    push_exp(32'h0000_4501, 32'hFFFF_FFFE, 1'b1, 1'b0);
    push_exp(32'h0000_0005, 32'h0, 1'b1, 1'b0);
    push_exp(32'h0000_0001, 32'h2, 1'b1, 1'b0);
    feed(32'h4501_1234);
    feed(32'h0001_0005);
    drain();

    // Reset mid-operation discards buffered halves, including a half-built straddle.
    bus.InstrReady = 1'b0;
    feed(32'h0513_0001);
    sample_edge();
    chk("prereset_valid", 32'(bus.InstrValid), 32'd1);
    advance();
    rst = 1'b1;
    sample_edge();
    chk("midrst_valid", 32'(bus.InstrValid), 32'd0);
    chk("midrst_ready", 32'(bus.FetchReady), 32'd0);
    advance();
    rst = 1'b0;
    sample_edge();
    chk("postrst_valid", 32'(bus.InstrValid), 32'd0);
    chk("postrst_pc", bus.InstrPc, 32'h0);
    advance();
    bus.InstrReady = 1'b1;
    push_exp(32'h0000_4501, 32'h0, 1'b1, 1'b0);
    push_exp(32'h0000_0001, 32'h2, 1'b1, 1'b0);
    feed(32'h0001_4501);
    drain();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
